// File: rtl/uart_tx_fifo.sv
// Purpose: UART 8N1 transmitter fed by a circular byte FIFO; optional even parity bit under `UART_TX_PARITY_EN.
// Latency: a push into an empty idle FIFO is popped on the next edge, and tx falls after that edge.
// Backpressure: full is asserted at FIFO_DEPTH entries; pushes while full are dropped silently.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               fpga_clk,
  input  logic               fpga_rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_nx;
  logic [BW-1:0]      baud_cnt, baud_nx;
  logic [2:0]         bit_idx, bit_nx, bit_inc;
  logic [7:0]         shift, shift_nx;
  logic               tx_nx;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         mem [FIFO_DEPTH];
  logic               push, pop, has_data, baud_done;

  // full uses the registered count, so a same-edge pop never frees room for a push
  assign full      = (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign busy      = (state != IDLE);
  assign push      = wr_en && !full;
  assign has_data  = (fifo_count != '0);
  assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign bit_inc   = bit_idx + 3'd1;

  // Byte storage; contents are only meaningful between the read and write pointers
  always_ff @(posedge fpga_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) state <= IDLE;
    else             state <= state_nx;
  end

  // Baud counter, bit index, shift register and the registered line output
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
    end
  end

  // Next-state and next-output decode; a stop bit with data pending chains straight into a start bit
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + BW'(1);
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        if (has_data) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nx = DATA;
          baud_nx  = '0;
          bit_nx   = 3'd0;
          tx_nx    = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
            tx_nx    = ^shift;
`else
            state_nx = STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            bit_nx = bit_inc;
            tx_nx  = shift[bit_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_nx = STOP;
          baud_nx  = '0;
          tx_nx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_nx = '0;
          if (has_data) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = '0;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule
